n_mem_read_sched: RTL and testbench
===================================

Name: n_mem_read_sched

Overview:
- Burst read scheduler that shares the single read port of the modulus word memory (n_mem, read-only, 2-cycle registered read) between two requesters, e.g. the Montgomery multiplier and the final-subtract unit.
- Each requester asks for a burst of consecutive 32-bit words (base, length).
- The block arbitrates round-robin at burst granularity and drives the memory address.
- It returns the read words with a per-requester valid, last and done, aligned to the memory latency.

Parameters:
- ADDR_WIDTH, 7, memory address width (matches `ADDR_WIDTH32`).
- DATA_WIDTH, 32, word width (matches `DATA_WIDTH32`).
- RD_LATENCY, 2, memory read latency in cycles; fixed at 2 (address register plus output register). Other values are unsupported.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester burst request; level, held until gnt.
- base0, base1  in  ADDR_WIDTH  start word address; sampled on the grant edge.
- len0, len1  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled on the grant edge.
- gnt  out  2  one-hot, one-cycle grant pulse.
- mem_address  out  ADDR_WIDTH  to n_mem address.
- mem_data  out  DATA_WIDTH  to n_mem data; tied to 0.
- mem_q  in  DATA_WIDTH  from n_mem q.
- rvalid  out  2  one-hot; rdata is valid for that requester.
- rlast  out  1  qualifies the final word of a burst.
- rdata  out  DATA_WIDTH  equals mem_q; meaningful only when rvalid != 0.
- done  out  2  one-cycle pulse at burst completion.
- busy  out  1  high while in ISSUE or while any read is in flight.

Behaviour:
- Reset (synchronous, active-high):
  - FSM to IDLE; address counter and remaining count to 0.
  - In-flight pipeline valids cleared; words in flight are dropped and produce no rvalid or done.
  - Round-robin pointer set so requester 0 wins the first tie.
  - gnt, rvalid, rlast, done, busy, mem_address all 0.
- FSM states:
  - IDLE, ISSUE.
- IDLE:
  - At an edge with req != 0: pick the winner (round-robin; single requester wins outright).
  - Latch its base into the address counter and its len into the remaining count.
  - Pulse its gnt bit for the following cycle and go to ISSUE.
  - If the latched len = 0: gnt pulse, no issue, done pulse in the same cycle as gnt; stay in IDLE and update the pointer.
- ISSUE:
  - Every cycle: mem_address = counter, and one issue-valid entry (tag = owner, last = (remaining==1)) enters a 2-deep shift pipeline.
  - At each edge: counter increments, wrapping modulo 2^ADDR_WIDTH; remaining decrements.
- Burst end:
  - At the edge where remaining==1: if the other requester (or the same one, by round-robin) has req high, grant it immediately with no bubble.
  - Otherwise go to IDLE.
  - Round-robin pointer toggles to the non-winner after each grant.
- Latency:
  - A word issued in cycle t appears with rvalid[tag]=1 in cycle t+2.
  - The first rvalid arrives 2 cycles after the gnt cycle.
  - rlast and done[tag] are both high in the cycle of the last word.
- Overlap:
  - Back-to-back bursts overlap in the pipeline; tags keep rvalid correct.
  - rvalid is never high for both requesters at once.
- No backpressure:
  - Consumers must accept rdata whenever rvalid is high.
- Grant rules:
  - A req dropped before gnt is legal and is simply not granted.
  - A req held high after gnt requests a new burst.
- When idle, mem_address holds its last value (no output toggling when idle).
- busy = (state==ISSUE) or any pipeline valid.

Decomposition:
- Shared package/include `_parameter.v` holds:
  - ADDR/DATA widths;
  - the RD_LATENCY constant;
  - FSM state encodings (IDLE=1'b0, ISSUE=1'b1).
- One natural sub-module: n_rd_pipe, the parameterized-depth valid/tag/last shift register (reused for other single-port memories).

Test Plan:
- Single burst: req=01, base0=5, len0=3 → gnt=01 in cycle 1; mem_address 5,6,7 in cycles 1-3; rvalid=01 in cycles 3-5 with rdata=n[5..7]; rlast and done0 in cycle 5.
- Contention: req=11 from reset, len0=len1=2, base1=20 → requester 0 granted first, then requester 1 with zero bubble; addresses 0,1,20,21 issued consecutively; rvalid 01,01,10,10.
- Wrap: base0=126, len0=4 → addresses 126,127,0,1; done0 after 4 words.
- len=0: req=10, len1=0 → gnt=10 and done=10 in the same cycle; no rvalid; FSM stays in IDLE.
- Full memory: len0=128, base0=0 → 128 consecutive rvalids; rlast only on word 127.
- Reset mid-burst: assert reset during the 2nd issue cycle of a len 8 burst → all outputs 0 the next cycle; no stale rvalid or done afterwards; the next request is served normally with requester 0 priority.

Source files
------------

// File: rtl/n_mem_read_sched_pkg.sv
// Shared widths, latency and FSM encoding for the n_mem burst read scheduler.
package n_mem_read_sched_pkg;
  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 32;
  localparam int RD_LATENCY = 2;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   len_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;
endpackage

// File: rtl/n_mem_read_sched_if.sv
// Requester and n_mem signals of the read scheduler.
interface n_mem_read_sched_if;
  import n_mem_read_sched_pkg::*;

  logic [1:0] req;
  addr_t      base0;
  addr_t      base1;
  len_t       len0;
  len_t       len1;
  logic [1:0] gnt;
  addr_t      mem_address;
  word_t      mem_data;
  word_t      mem_q;
  logic [1:0] rvalid;
  logic       rlast;
  word_t      rdata;
  logic [1:0] done;
  logic       busy;

  modport slave (
    input  req, base0, base1, len0, len1, mem_q,
    output gnt, mem_address, mem_data,
    output rvalid, rlast, rdata, done, busy
  );

  modport master (
    output req, base0, base1, len0, len1, mem_q,
    input  gnt, mem_address, mem_data,
    input  rvalid, rlast, rdata, done, busy
  );
endinterface

// File: rtl/n_mem_read_sched_pipe.sv
// n_rd_pipe: valid/tag/last shift register tracking reads in flight
// through a fixed-latency single-port memory.
module n_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_last,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last,
  output logic             any
);
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] lst;
  logic [TAG_W-1:0] tag [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      lst <= '0;
      for (int i = 0; i < DEPTH; i++)
        tag[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      lst[0] <= in_last;
      tag[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_last  = vld[DEPTH-1] & lst[DEPTH-1];
  assign out_tag   = tag[DEPTH-1];
  assign any       = |vld;
endmodule

// File: rtl/n_mem_read_sched.sv
// Round-robin burst read scheduler sharing the n_mem read port
// between two requesters.
module n_mem_read_sched
  import n_mem_read_sched_pkg::*;
(
  input logic               clock,
  input logic               reset,
  n_mem_read_sched_if.slave bus
);
  localparam len_t  LEN_ONE = len_t'(1);
  localparam addr_t ADR_ONE = addr_t'(1);

  state_t     state, state_nx;
  addr_t      cnt, cnt_nx;
  len_t       rem, rem_nx;
  logic       owner, owner_nx;
  logic       ptr, ptr_nx;
  logic [1:0] gnt_q, gnt_nx;
  logic [1:0] zdone_q, zdone_nx;

  logic       iss, last_iss, win;
  len_t       wlen;
  addr_t      wbase;

  logic       p_vld, p_tag, p_last, p_any;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      gnt_q   <= '0;
      zdone_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rem     <= rem_nx;
      owner   <= owner_nx;
      ptr     <= ptr_nx;
      gnt_q   <= gnt_nx;
      zdone_q <= zdone_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rem_nx   = rem;
    owner_nx = owner;
    ptr_nx   = ptr;
    gnt_nx   = '0;
    zdone_nx = '0;
    iss      = (state == ISSUE);
    last_iss = iss && (rem == LEN_ONE);
    win      = (bus.req == 2'b11) ? ptr : bus.req[1];
    wlen     = win ? bus.len1 : bus.len0;
    wbase    = win ? bus.base1 : bus.base0;

    if (iss) begin
      cnt_nx = cnt + ADR_ONE;
      rem_nx = rem - LEN_ONE;
    end
    // Last word: freeze the counter so mem_address holds while idle.
    if (last_iss) begin
      state_nx = IDLE;
      cnt_nx   = cnt;
    end

    if ((!iss || last_iss) && (bus.req != 2'b00)) begin
      gnt_nx[win] = 1'b1;
      ptr_nx      = ~win;
      if (wlen == '0) begin
        zdone_nx[win] = 1'b1;
      end else begin
        state_nx = ISSUE;
        cnt_nx   = wbase;
        rem_nx   = wlen;
        owner_nx = win;
      end
    end
  end

  n_rd_pipe #(
    .DEPTH (RD_LATENCY),
    .TAG_W (1)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (iss),
    .in_tag    (owner),
    .in_last   (last_iss),
    .out_valid (p_vld),
    .out_tag   (p_tag),
    .out_last  (p_last),
    .any       (p_any)
  );

  assign bus.gnt         = gnt_q;
  assign bus.mem_address = cnt;
  assign bus.mem_data    = '0;
  assign bus.rvalid      = {p_vld & p_tag, p_vld & ~p_tag};
  assign bus.rlast       = p_last;
  assign bus.rdata       = bus.mem_q;
  assign bus.done        = zdone_q | {p_last & p_tag, p_last & ~p_tag};
  assign bus.busy        = iss | p_any;
endmodule

// File: tb/tb_n_mem_read_sched.sv
// Directed bench for n_mem_read_sched with a 2-cycle n_mem model.
module tb_n_mem_read_sched;
  import n_mem_read_sched_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  addr_t a_q  = '0;

  n_mem_read_sched_if bus ();

  n_mem_read_sched dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic word_t mem_word(input int i);
    return {8'hA5, 8'(i), 16'h1000 + 16'(i * 3)};
  endfunction

  always @(posedge clock) begin
    a_q        <= bus.mem_address;
    bus.mem_q  <= mem_word(int'(a_q));
  end

  task automatic chk(input string t, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask

  task automatic cyc(input string nm, input int n,
                     input logic [1:0] g, input logic [1:0] rv,
                     input logic rl, input logic [1:0] dn,
                     input logic bz, input int adr, input int dw);
    string t;
    @(negedge clock);
    t = $sformatf("%s c%0d", nm, n);
    chk({t, " gnt"}, 32'(bus.gnt), 32'(g));
    chk({t, " rvalid"}, 32'(bus.rvalid), 32'(rv));
    chk({t, " rlast"}, 32'(bus.rlast), 32'(rl));
    chk({t, " done"}, 32'(bus.done), 32'(dn));
    chk({t, " busy"}, 32'(bus.busy), 32'(bz));
    if (adr >= 0)
      chk({t, " addr"}, 32'(bus.mem_address), 32'(adr));
    if (dw >= 0)
      chk({t, " rdata"}, bus.rdata, mem_word(dw));
  endtask

  initial begin
    bus.req   = 2'b00;
    bus.base0 = '0;
    bus.base1 = '0;
    bus.len0  = '0;
    bus.len1  = '0;

    // reset state
    cyc("rst", 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, -1);
    cyc("rst", 1, 2'b00, 2'b00, 0, 2'b00, 0, 0, -1);
    chk("rst mem_data", bus.mem_data, 32'h0);

    // single burst
    reset = 0;
    bus.req = 2'b01; bus.base0 = 7'd5; bus.len0 = 8'd3;
    cyc("one", 1, 2'b01, 2'b00, 0, 2'b00, 1, 5, -1);
    bus.req = 2'b00;
    cyc("one", 2, 2'b00, 2'b00, 0, 2'b00, 1, 6, -1);
    cyc("one", 3, 2'b00, 2'b01, 0, 2'b00, 1, 7, 5);
    cyc("one", 4, 2'b00, 2'b01, 0, 2'b00, 1, 7, 6);
    cyc("one", 5, 2'b00, 2'b01, 1, 2'b01, 1, 7, 7);
    cyc("one", 6, 2'b00, 2'b00, 0, 2'b00, 0, 7, -1);

    // contention from reset
    reset = 1;
    cyc("crst", 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, -1);
    reset = 0;
    bus.req = 2'b11;
    bus.base0 = 7'd0;  bus.len0 = 8'd2;
    bus.base1 = 7'd20; bus.len1 = 8'd2;
    cyc("cont", 1, 2'b01, 2'b00, 0, 2'b00, 1, 0, -1);
    bus.req = 2'b10;
    cyc("cont", 2, 2'b00, 2'b00, 0, 2'b00, 1, 1, -1);
    cyc("cont", 3, 2'b10, 2'b01, 0, 2'b00, 1, 20, 0);
    bus.req = 2'b00;
    cyc("cont", 4, 2'b00, 2'b01, 1, 2'b01, 1, 21, 1);
    cyc("cont", 5, 2'b00, 2'b10, 0, 2'b00, 1, 21, 20);
    cyc("cont", 6, 2'b00, 2'b10, 1, 2'b10, 1, 21, 21);
    cyc("cont", 7, 2'b00, 2'b00, 0, 2'b00, 0, 21, -1);

    // address wrap
    bus.req = 2'b01; bus.base0 = 7'd126; bus.len0 = 8'd4;
    cyc("wrap", 1, 2'b01, 2'b00, 0, 2'b00, 1, 126, -1);
    bus.req = 2'b00;
    cyc("wrap", 2, 2'b00, 2'b00, 0, 2'b00, 1, 127, -1);
    cyc("wrap", 3, 2'b00, 2'b01, 0, 2'b00, 1, 0, 126);
    cyc("wrap", 4, 2'b00, 2'b01, 0, 2'b00, 1, 1, 127);
    cyc("wrap", 5, 2'b00, 2'b01, 0, 2'b00, 1, 1, 0);
    cyc("wrap", 6, 2'b00, 2'b01, 1, 2'b01, 1, 1, 1);
    cyc("wrap", 7, 2'b00, 2'b00, 0, 2'b00, 0, 1, -1);

    // zero-length burst
    bus.req = 2'b10; bus.base1 = 7'd50; bus.len1 = 8'd0;
    cyc("zero", 1, 2'b10, 2'b00, 0, 2'b10, 0, 1, -1);
    bus.req = 2'b00;
    cyc("zero", 2, 2'b00, 2'b00, 0, 2'b00, 0, 1, -1);
    cyc("zero", 3, 2'b00, 2'b00, 0, 2'b00, 0, 1, -1);

    // full memory sweep
    bus.req = 2'b01; bus.base0 = 7'd0; bus.len0 = 8'd128;
    cyc("full", 1, 2'b01, 2'b00, 0, 2'b00, 1, 0, -1);
    bus.req = 2'b00;
    for (int k = 2; k <= 130; k++)
      cyc("full", k, 2'b00, (k >= 3) ? 2'b01 : 2'b00, k == 130,
          (k == 130) ? 2'b01 : 2'b00, 1'b1,
          (k <= 128) ? k - 1 : 127, (k >= 3) ? k - 3 : -1);
    cyc("full", 131, 2'b00, 2'b00, 0, 2'b00, 0, 127, -1);

    // reset in the middle of a burst
    bus.req = 2'b01; bus.base0 = 7'd40; bus.len0 = 8'd8;
    cyc("mid", 1, 2'b01, 2'b00, 0, 2'b00, 1, 40, -1);
    bus.req = 2'b00;
    cyc("mid", 2, 2'b00, 2'b00, 0, 2'b00, 1, 41, -1);
    reset = 1;
    cyc("mid", 3, 2'b00, 2'b00, 0, 2'b00, 0, 0, -1);
    reset = 0;
    cyc("mid", 4, 2'b00, 2'b00, 0, 2'b00, 0, 0, -1);
    cyc("mid", 5, 2'b00, 2'b00, 0, 2'b00, 0, 0, -1);
    cyc("mid", 6, 2'b00, 2'b00, 0, 2'b00, 0, 0, -1);

    bus.req = 2'b11;
    bus.base0 = 7'd3; bus.len0 = 8'd1;
    bus.base1 = 7'd9; bus.len1 = 8'd1;
    cyc("post", 1, 2'b01, 2'b00, 0, 2'b00, 1, 3, -1);
    bus.req = 2'b10;
    cyc("post", 2, 2'b10, 2'b00, 0, 2'b00, 1, 9, -1);
    bus.req = 2'b00;
    cyc("post", 3, 2'b00, 2'b01, 1, 2'b01, 1, 9, 3);
    cyc("post", 4, 2'b00, 2'b10, 1, 2'b10, 1, 9, 9);
    cyc("post", 5, 2'b00, 2'b00, 0, 2'b00, 0, 9, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
